// File: rtl/bit_timing_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : bit_timing_sequencer_if
// Description : Control, length, resync and status bundle of the CAN
//               bit-time sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface bit_timing_sequencer_if;
  logic       enable;
  logic       tq_tick;
  logic [3:0] prop_seg;
  logic [3:0] phase_seg1;
  logic [3:0] phase_seg2;
  logic       hard_sync_request;
  logic       resync_required;
  logic [3:0] resync_adjustment;
  logic       resync_direction;
  logic [1:0] current_segment;
  logic [4:0] quanta_counter;
  logic       sample_point;
  logic       tx_point;
  logic       resync_applied;

  modport master (
    output enable, tq_tick, prop_seg, phase_seg1, phase_seg2,
           hard_sync_request, resync_required, resync_adjustment,
           resync_direction,
    input  current_segment, quanta_counter, sample_point, tx_point,
           resync_applied
  );

  modport slave (
    input  enable, tq_tick, prop_seg, phase_seg1, phase_seg2,
           hard_sync_request, resync_required, resync_adjustment,
           resync_direction,
    output current_segment, quanta_counter, sample_point, tx_point,
           resync_applied
  );
endinterface
`default_nettype wire

// File: rtl/bit_timing_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bit_timing_sequencer
// Description : Steps SYNC/PROP/PS1/PS2 per time quantum with resync and
//               hard sync support; emits sample and transmit point strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_timing_sequencer #(
  parameter int MAX_SEG = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  bit_timing_sequencer_if.slave  bus
);

  localparam logic [4:0] c_max_seg = 5'(MAX_SEG);
  localparam logic [4:0] c_max_ps1 = 5'(2 * MAX_SEG);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_PROP = 3'd2,
    ST_PS1  = 3'd3,
    ST_PS2  = 3'd4
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [4:0] r_qc, w_qc_nxt;
  logic [4:0] r_len_prop, w_len_prop_nxt;
  logic [4:0] r_len1, w_len1_nxt;
  logic [4:0] r_len2, w_len2_nxt;
  logic       r_hs_pend, w_hs_pend_nxt;
  logic       r_rs_used, w_rs_used_nxt;
  logic       r_sample, w_sample_nxt;
  logic       r_tx, w_tx_nxt;
  logic       r_rs_applied, w_rs_applied_nxt;

  logic [4:0] w_lat_prop, w_lat_len1, w_lat_len2;
  logic [4:0] w_adj, w_len1_add, w_len2_sub, w_len2_short;
  logic       w_hs, w_rs_ok, w_rs_lengthen, w_rs_shorten;

  function automatic logic [4:0] clamp_len(input logic [3:0] raw,
                                           input logic [4:0] min_len);
    logic [4:0] v;
    v = {1'b0, raw};
    if (v < min_len)   v = min_len;
    if (v > c_max_seg) v = c_max_seg;
    return v;
  endfunction

  assign w_lat_prop = clamp_len(bus.prop_seg,   5'd1);
  assign w_lat_len1 = clamp_len(bus.phase_seg1, 5'd1);
  assign w_lat_len2 = clamp_len(bus.phase_seg2, 5'd2);

  assign w_adj        = ({1'b0, bus.resync_adjustment} > c_max_seg) ?
                        c_max_seg : {1'b0, bus.resync_adjustment};
  assign w_len1_add   = ((r_len1 + w_adj) > c_max_ps1) ? c_max_ps1 : (r_len1 + w_adj);
  assign w_len2_sub   = (r_len2 > w_adj) ? (r_len2 - w_adj) : 5'd0;
  // PS2 can never be shortened below the quantum already elapsed
  assign w_len2_short = (w_len2_sub > r_qc) ? w_len2_sub : r_qc;

  assign w_hs          = r_hs_pend | bus.hard_sync_request;
  assign w_rs_ok       = bus.resync_required & ~r_rs_used & ~w_hs & (r_state != ST_IDLE);
  assign w_rs_lengthen = w_rs_ok & ~bus.resync_direction &
                         ((r_state == ST_PROP) || (r_state == ST_PS1));
  assign w_rs_shorten  = w_rs_ok & bus.resync_direction & (r_state == ST_PS2);

  always_comb begin
    w_state_nxt      = r_state;
    w_qc_nxt         = r_qc;
    w_len_prop_nxt   = r_len_prop;
    w_len1_nxt       = r_len1;
    w_len2_nxt       = r_len2;
    w_hs_pend_nxt    = w_hs;
    w_rs_used_nxt    = r_rs_used;
    w_sample_nxt     = 1'b0;
    w_tx_nxt         = 1'b0;
    w_rs_applied_nxt = 1'b0;

    if (!bus.enable) begin
      w_state_nxt   = ST_IDLE;
      w_qc_nxt      = 5'd0;
      w_hs_pend_nxt = 1'b0;
      w_rs_used_nxt = 1'b0;
    end else begin
      if (w_rs_lengthen) begin
        w_len1_nxt       = w_len1_add;
        w_rs_used_nxt    = 1'b1;
        w_rs_applied_nxt = 1'b1;
      end
      if (w_rs_shorten) begin
        w_len2_nxt       = w_len2_short;
        w_rs_used_nxt    = 1'b1;
        w_rs_applied_nxt = 1'b1;
      end

      if (bus.tq_tick) begin
        if (w_hs) begin
          w_state_nxt    = ST_PROP;
          w_qc_nxt       = 5'd1;
          w_len_prop_nxt = w_lat_prop;
          w_len1_nxt     = w_lat_len1;
          w_len2_nxt     = w_lat_len2;
          w_hs_pend_nxt  = 1'b0;
          w_rs_used_nxt  = 1'b0;
        end else begin
          // w_len1_nxt / w_len2_nxt already carry any resync accepted this cycle
          case (r_state)
            ST_IDLE, ST_PS2: begin
              if ((r_state == ST_IDLE) || (r_qc >= w_len2_nxt)) begin
                w_state_nxt    = ST_SYNC;
                w_qc_nxt       = 5'd1;
                w_tx_nxt       = 1'b1;
                w_len_prop_nxt = w_lat_prop;
                w_len1_nxt     = w_lat_len1;
                w_len2_nxt     = w_lat_len2;
                w_rs_used_nxt  = 1'b0;
              end else begin
                w_qc_nxt = r_qc + 5'd1;
              end
            end
            ST_SYNC: begin
              w_state_nxt = ST_PROP;
              w_qc_nxt    = 5'd1;
            end
            ST_PROP: begin
              if (r_qc >= r_len_prop) begin
                w_state_nxt = ST_PS1;
                w_qc_nxt    = 5'd1;
              end else begin
                w_qc_nxt = r_qc + 5'd1;
              end
            end
            ST_PS1: begin
              if (r_qc >= w_len1_nxt) begin
                w_state_nxt  = ST_PS2;
                w_qc_nxt     = 5'd1;
                w_sample_nxt = 1'b1;
              end else begin
                w_qc_nxt = r_qc + 5'd1;
              end
            end
            default: begin
              w_state_nxt = ST_IDLE;
              w_qc_nxt    = 5'd0;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_qc         <= 5'd0;
      r_len_prop   <= 5'd1;
      r_len1       <= 5'd1;
      r_len2       <= 5'd2;
      r_hs_pend    <= 1'b0;
      r_rs_used    <= 1'b0;
      r_sample     <= 1'b0;
      r_tx         <= 1'b0;
      r_rs_applied <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_qc         <= w_qc_nxt;
      r_len_prop   <= w_len_prop_nxt;
      r_len1       <= w_len1_nxt;
      r_len2       <= w_len2_nxt;
      r_hs_pend    <= w_hs_pend_nxt;
      r_rs_used    <= w_rs_used_nxt;
      r_sample     <= w_sample_nxt;
      r_tx         <= w_tx_nxt;
      r_rs_applied <= w_rs_applied_nxt;
    end
  end

  always_comb begin
    case (r_state)
      ST_PROP: bus.current_segment = 2'b01;
      ST_PS1:  bus.current_segment = 2'b10;
      ST_PS2:  bus.current_segment = 2'b11;
      default: bus.current_segment = 2'b00;
    endcase
  end

  assign bus.quanta_counter = r_qc;
  assign bus.sample_point   = r_sample;
  assign bus.tx_point       = r_tx;
  assign bus.resync_applied = r_rs_applied;

endmodule
`default_nettype wire

// File: tb/tb_bit_timing_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_timing_sequencer
// Description : Directed bench for bit_timing_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_timing_sequencer;

  localparam logic [1:0] c_sync = 2'd0;
  localparam logic [1:0] c_prop = 2'd1;
  localparam logic [1:0] c_ps1  = 2'd2;
  localparam logic [1:0] c_ps2  = 2'd3;

  logic clock;
  logic reset_n;
  int   n_vec;
  int   n_err;

  bit_timing_sequencer_if bus ();

  bit_timing_sequencer #(.MAX_SEG(8)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [9:0] obs;
  assign obs = {bus.current_segment, bus.quanta_counter, bus.sample_point,
                bus.tx_point, bus.resync_applied};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (seg,qc,sample,tx,applied)", tag, got, exp);
    end
  endtask

  // sample_point expected only on entry to PS2, tx_point only on entry to SYNC
  task automatic step_chk(input string tag, input logic [1:0] seg, input logic [4:0] qc,
                          input logic applied);
    logic [9:0] exp;
    @(posedge clock);
    #1;
    exp = {seg, qc, (seg == c_ps2 && qc == 5'd1), (seg == c_sync && qc == 5'd1), applied};
    check(tag, 32'(obs), 32'(exp));
  endtask

  task automatic run_seg(input string tag, input logic [1:0] seg, input int from, input int to);
    for (int q = from; q <= to; q++) step_chk(tag, seg, 5'(q), 1'b0);
  endtask

  task automatic run_tail(input string tag, input int lp, input int l1, input int l2);
    run_seg(tag, c_prop, 1, lp);
    run_seg(tag, c_ps1,  1, l1);
    run_seg(tag, c_ps2,  1, l2);
  endtask

  task automatic run_bit(input string tag, input int lp, input int l1, input int l2);
    step_chk(tag, c_sync, 5'd1, 1'b0);
    run_tail(tag, lp, l1, l2);
  endtask

  task automatic set_rs(input logic req, input logic dir, input logic [3:0] adj);
    bus.resync_required   = req;
    bus.resync_direction  = dir;
    bus.resync_adjustment = adj;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n               = 1'b0;
    bus.enable            = 1'b0;
    bus.tq_tick           = 1'b0;
    bus.prop_seg          = 4'd8;
    bus.phase_seg1        = 4'd8;
    bus.phase_seg2        = 4'd8;
    bus.hard_sync_request = 1'b0;
    set_rs(1'b0, 1'b0, 4'd0);

    step_chk("reset", c_sync, 5'd0, 1'b0);
    step_chk("reset", c_sync, 5'd0, 1'b0);
    reset_n = 1'b1;
    step_chk("idle", c_sync, 5'd0, 1'b0);

    // nominal 25 Tq bits
    bus.enable  = 1'b1;
    bus.tq_tick = 1'b1;
    run_bit("nominal", 8, 8, 8);
    run_bit("nominal2", 8, 8, 8);

    // lengthen PS1 by 4 from PROP qc=3
    step_chk("lng_sync", c_sync, 5'd1, 1'b0);
    run_seg("lng_prop", c_prop, 1, 3);
    set_rs(1'b1, 1'b0, 4'd4);
    step_chk("lng_acc", c_prop, 5'd4, 1'b1);
    set_rs(1'b0, 1'b0, 4'd0);
    run_seg("lng_prop", c_prop, 5, 8);
    run_seg("lng_ps1", c_ps1, 1, 12);
    run_seg("lng_ps2", c_ps2, 1, 8);
    run_bit("lng_next", 8, 8, 8);

    // shorten PS2 by 4 at qc=2
    step_chk("sht_sync", c_sync, 5'd1, 1'b0);
    run_seg("sht_prop", c_prop, 1, 8);
    run_seg("sht_ps1", c_ps1, 1, 8);
    run_seg("sht_ps2", c_ps2, 1, 2);
    set_rs(1'b1, 1'b1, 4'd4);
    step_chk("sht_acc", c_ps2, 5'd3, 1'b1);
    set_rs(1'b0, 1'b0, 4'd0);
    step_chk("sht_end", c_ps2, 5'd4, 1'b0);

    // shorten by 8 at qc=5: SYNC on the very next tick
    step_chk("sht8_sync", c_sync, 5'd1, 1'b0);
    run_seg("sht8_prop", c_prop, 1, 8);
    run_seg("sht8_ps1", c_ps1, 1, 8);
    run_seg("sht8_ps2", c_ps2, 1, 5);
    set_rs(1'b1, 1'b1, 4'd8);
    step_chk("sht8_acc", c_sync, 5'd1, 1'b1);
    set_rs(1'b0, 1'b0, 4'd0);
    run_tail("sht8_tail", 8, 8, 8);

    // wrong-segment request ignored; second request in a bit ignored
    step_chk("dbl_sync", c_sync, 5'd1, 1'b0);
    step_chk("dbl_prop", c_prop, 5'd1, 1'b0);
    set_rs(1'b1, 1'b1, 4'd4);
    step_chk("dbl_wrongseg", c_prop, 5'd2, 1'b0);
    set_rs(1'b1, 1'b0, 4'd2);
    step_chk("dbl_acc", c_prop, 5'd3, 1'b1);
    set_rs(1'b0, 1'b0, 4'd0);
    run_seg("dbl_prop", c_prop, 4, 8);
    run_seg("dbl_ps1", c_ps1, 1, 3);
    set_rs(1'b1, 1'b0, 4'd4);
    step_chk("dbl_ignored", c_ps1, 5'd4, 1'b0);
    set_rs(1'b0, 1'b0, 4'd0);
    run_seg("dbl_ps1", c_ps1, 5, 10);
    run_seg("dbl_ps2", c_ps2, 1, 8);

    // hard sync in PS1 qc=5 with a simultaneous resync
    step_chk("hs_sync", c_sync, 5'd1, 1'b0);
    run_seg("hs_prop", c_prop, 1, 8);
    run_seg("hs_ps1", c_ps1, 1, 5);
    bus.hard_sync_request = 1'b1;
    set_rs(1'b1, 1'b0, 4'd4);
    step_chk("hs_jump", c_prop, 5'd1, 1'b0);
    bus.hard_sync_request = 1'b0;
    set_rs(1'b0, 1'b0, 4'd0);
    run_seg("hs_prop", c_prop, 2, 8);
    run_seg("hs_ps1", c_ps1, 1, 8);
    run_seg("hs_ps2", c_ps2, 1, 8);
    run_bit("hs_next", 8, 8, 8);

    // reset mid PS2, then restart with clamped lengths changed mid-bit
    step_chk("rst_sync", c_sync, 5'd1, 1'b0);
    run_seg("rst_prop", c_prop, 1, 8);
    run_seg("rst_ps1", c_ps1, 1, 8);
    run_seg("rst_ps2", c_ps2, 1, 6);
    reset_n = 1'b0;
    step_chk("rst_mid", c_sync, 5'd0, 1'b0);
    bus.enable = 1'b0;
    step_chk("rst_hold", c_sync, 5'd0, 1'b0);
    reset_n = 1'b1;
    step_chk("en_low", c_sync, 5'd0, 1'b0);
    bus.prop_seg   = 4'd0;
    bus.phase_seg1 = 4'd12;
    bus.phase_seg2 = 4'd1;
    bus.enable     = 1'b1;
    step_chk("restart", c_sync, 5'd1, 1'b0);
    bus.prop_seg   = 4'd8;
    bus.phase_seg1 = 4'd8;
    bus.phase_seg2 = 4'd8;
    run_tail("clamp", 1, 8, 2);
    run_bit("relatch", 8, 8, 8);

    // no tick holds; pending hard sync dropped by enable low
    bus.tq_tick = 1'b0;
    step_chk("no_tick", c_ps2, 5'd8, 1'b0);
    bus.hard_sync_request = 1'b1;
    step_chk("hs_pend", c_ps2, 5'd8, 1'b0);
    bus.hard_sync_request = 1'b0;
    bus.enable = 1'b0;
    step_chk("en_fall", c_sync, 5'd0, 1'b0);
    bus.enable  = 1'b1;
    bus.tq_tick = 1'b1;
    step_chk("hs_dropped", c_sync, 5'd1, 1'b0);
    run_seg("pend_prop", c_prop, 1, 3);

    // pending hard sync taken on a later tick
    bus.tq_tick = 1'b0;
    bus.hard_sync_request = 1'b1;
    step_chk("hs_notick", c_prop, 5'd3, 1'b0);
    bus.hard_sync_request = 1'b0;
    step_chk("hs_wait", c_prop, 5'd3, 1'b0);
    bus.tq_tick = 1'b1;
    step_chk("hs_late", c_prop, 5'd1, 1'b0);
    step_chk("hs_late2", c_prop, 5'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
